// File: rtl/psx_pad_responder.sv
// PlayStation controller-port responder: shifts the digital pad reply out on dat while capturing host commands.
// Define PSX_PAD_ANALOG_EN to report ID 0x73 and append four 0x80 stick bytes; default build is digital-only (ID 0x41).
module psx_pad_responder #(
  parameter int ACK_DELAY = 8,
  parameter int ACK_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        att,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] buttons,
  output logic        dat,
  output logic        ack,
  output logic [7:0]  rx_byte,
  output logic        rx_valid
);

`ifdef PSX_PAD_ANALOG_EN
  localparam logic [7:0] PAD_ID   = 8'h73;
  localparam logic [3:0] LAST_IDX = 4'd8;
  localparam logic [7:0] TAIL_BYTE = 8'h80;
`else
  localparam logic [7:0] PAD_ID   = 8'h41;
  localparam logic [3:0] LAST_IDX = 4'd4;
  localparam logic [7:0] TAIL_BYTE = 8'hFF;
`endif

  localparam logic [7:0] DLY_LOAD = 8'(ACK_DELAY - 1);
  localparam logic [7:0] WID_LOAD = 8'(ACK_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    ACK_WAIT = 3'd2,
    ACK_LOW  = 3'd3,
    IGNORE   = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Sync chains: [0] first stage, [1] synchronized value, [2] previous synchronized value.
  logic [2:0]  att_sync_q, clk_sync_q;
  logic [1:0]  cmd_sync_q;
  logic [1:0]  prime_q, prime_d;
  logic        armed_q, armed_d;

  state_t      state_q, state_d;
  logic        dat_q, dat_d;
  logic        ack_q, ack_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] btn_q, btn_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;

  logic        att_fall, att_rise, clk_fall, clk_rise;
  logic [7:0]  tx_cur, rx_new;

  assign att_fall = att_sync_q[2] & ~att_sync_q[1];
  assign att_rise = ~att_sync_q[2] & att_sync_q[1];
  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign clk_rise = ~clk_sync_q[2] & clk_sync_q[1];
  assign rx_new   = {cmd_sync_q[1], rx_shift_q[6:0]};

  always_comb begin
    tx_cur = TAIL_BYTE;
    case (byte_idx_q)
      4'd0:    tx_cur = 8'hFF;
      4'd1:    tx_cur = PAD_ID;
      4'd2:    tx_cur = 8'h5A;
      4'd3:    tx_cur = btn_q[7:0];
      4'd4:    tx_cur = btn_q[15:8];
      default: tx_cur = TAIL_BYTE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dat_d      = dat_q;
    ack_d      = ack_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    cnt_d      = cnt_q;
    btn_d      = btn_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    prime_d    = (prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
    // A select only counts once att has been genuinely seen high since reset.
    armed_d    = armed_q | ((prime_q == 2'd2) & att_sync_q[1]);

    case (state_q)
      IDLE: begin
        dat_d      = 1'b1;
        ack_d      = 1'b1;
        bit_cnt_d  = 3'd0;
        byte_idx_d = 4'd0;
        if (att_fall && armed_q) begin
          btn_d   = buttons;
          dat_d   = tx_cur[0];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (clk_fall) begin
          dat_d = tx_cur[bit_cnt_q];
        end else if (clk_rise) begin
          rx_shift_d[bit_cnt_q] = cmd_sync_q[1];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_byte_d  = rx_new;
            rx_valid_d = 1'b1;
            bit_cnt_d  = 3'd0;
            byte_idx_d = byte_idx_q + 4'd1;
            if ((byte_idx_q == 4'd0 && rx_new != 8'h01) ||
                (byte_idx_q == 4'd1 && rx_new != 8'h42)) begin
              state_d = IGNORE;
              dat_d   = 1'b1;
            end else if (byte_idx_q == LAST_IDX) begin
              state_d = DONE;
              dat_d   = 1'b1;
            end else begin
              state_d = ACK_WAIT;
              cnt_d   = DLY_LOAD;
            end
          end
        end
      end
      ACK_WAIT, ACK_LOW: begin
        // An impatient host clocking the next byte cancels the acknowledge.
        if (clk_fall) begin
          ack_d   = 1'b1;
          dat_d   = tx_cur[0];
          state_d = SHIFT;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (state_q == ACK_WAIT) begin
          ack_d   = 1'b0;
          cnt_d   = WID_LOAD;
          state_d = ACK_LOW;
        end else begin
          ack_d   = 1'b1;
          state_d = SHIFT;
        end
      end
      IGNORE, DONE: begin
        dat_d = 1'b1;
        ack_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && att_rise) begin
      state_d    = IDLE;
      dat_d      = 1'b1;
      ack_d      = 1'b1;
      bit_cnt_d  = 3'd0;
      byte_idx_d = 4'd0;
      cnt_d      = 8'd0;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      att_sync_q <= 3'b111;
      clk_sync_q <= 3'b111;
      cmd_sync_q <= 2'b11;
      prime_q    <= 2'd0;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      dat_q      <= 1'b1;
      ack_q      <= 1'b1;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      cnt_q      <= 8'd0;
      btn_q      <= 16'hFFFF;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      att_sync_q <= {att_sync_q[1:0], att};
      clk_sync_q <= {clk_sync_q[1:0], psx_clk};
      cmd_sync_q <= {cmd_sync_q[0], cmd};
      prime_q    <= prime_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      dat_q      <= dat_d;
      ack_q      <= ack_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      cnt_q      <= cnt_d;
      btn_q      <= btn_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign dat      = dat_q;
  assign ack      = ack_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_psx_pad_responder.sv
// Directed bench for psx_pad_responder: full frame, bad header, early deselect, early clock, mid-frame reset.
module tb_psx_pad_responder;

  localparam int ACK_DELAY = 8;
  localparam int ACK_WIDTH = 4;
  localparam int HALF      = 4;
`ifdef PSX_PAD_ANALOG_EN
  localparam logic [7:0] EXP_ID = 8'h73;
  localparam int         NBYTES = 9;
`else
  localparam logic [7:0] EXP_ID = 8'h41;
  localparam int         NBYTES = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n, att, psx_clk, cmd;
  logic [15:0] buttons;
  logic        dat, ack, rx_valid;
  logic [7:0]  rx_byte;

  int n_vec = 0;
  int n_err = 0;

  psx_pad_responder #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .att(att), .psx_clk(psx_clk), .cmd(cmd),
    .buttons(buttons), .dat(dat), .ack(ack), .rx_byte(rx_byte), .rx_valid(rx_valid)
  );

  always #250 clk = ~clk;

  // Monitor: logs received bytes, ack pulse delays (from rx_valid) and widths.
  logic [7:0] rx_q[$];
  int         ack_dly_q[$];
  int         ack_wid_q[$];
  int         since_rxv = 0;
  int         cur_w = 0;
  logic       ack_prev = 1'b1;

  always @(posedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_q.push_back(rx_byte);
      since_rxv <= 1;
    end else if (since_rxv < 10000) begin
      since_rxv <= since_rxv + 1;
    end
    if (ack === 1'b0 && ack_prev === 1'b1) ack_dly_q.push_back(since_rxv);
    if (ack === 1'b0) cur_w <= cur_w + 1;
    else if (ack_prev === 1'b0) begin
      ack_wid_q.push_back(cur_w);
      cur_w <= 0;
    end
    ack_prev <= ack;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] c, input int tail, output logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      psx_clk = 1'b0;
      cmd     = c[i];
      cycles(HALF);
      d[i]    = dat;
      psx_clk = 1'b1;
      cycles((i == 7) ? tail : HALF);
    end
  endtask

  task automatic send_bits(input logic [7:0] c, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      psx_clk = 1'b0;
      cmd     = c[i];
      cycles(HALF);
      psx_clk = 1'b1;
      cycles(HALF);
    end
  endtask

  function automatic logic [7:0] exp_tx(input int idx, input logic [15:0] btn);
    case (idx)
      0: return 8'hFF;
      1: return EXP_ID;
      2: return 8'h5A;
      3: return btn[7:0];
      4: return btn[15:8];
      default: return 8'h80;
    endcase
  endfunction

  function automatic logic [7:0] host_cmd(input int idx);
    case (idx)
      0: return 8'h01;
      1: return 8'h42;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    logic [7:0] d;
    int r0, a0, w0;

    rst_n = 1'b0; att = 1'b1; psx_clk = 1'b1; cmd = 1'b1; buttons = 16'hFFFF;
    cycles(3);
    check("rst_dat", {15'd0, dat}, 16'd1);
    check("rst_ack", {15'd0, ack}, 16'd1);
    check("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
    check("rst_rx_byte", {8'd0, rx_byte}, 16'h0000);
    rst_n = 1'b1;
    cycles(10);

    // Full frame; buttons change after byte 1 but the snapshot must be sent.
    r0 = rx_q.size(); a0 = ack_dly_q.size(); w0 = ack_wid_q.size();
    buttons = 16'hFFFE;
    att = 1'b0;
    cycles(10);
    for (int i = 0; i < NBYTES; i++) begin
      send_byte(host_cmd(i), 20, d);
      check($sformatf("frame_dat%0d", i), {8'd0, d}, {8'd0, exp_tx(i, 16'hFFFE)});
      if (i == 1) buttons = 16'h0000;
    end
    check("frame_rx_count", 16'(rx_q.size() - r0), 16'(NBYTES));
    for (int i = 0; i < NBYTES; i++)
      check($sformatf("frame_rx%0d", i), {8'd0, rx_q[r0 + i]}, {8'd0, host_cmd(i)});
    check("frame_ack_count", 16'(ack_dly_q.size() - a0), 16'(NBYTES - 1));
    for (int i = 0; i < NBYTES - 1; i++) begin
      check($sformatf("ack_delay%0d", i), 16'(ack_dly_q[a0 + i]), 16'(ACK_DELAY));
      check($sformatf("ack_width%0d", i), 16'(ack_wid_q[w0 + i]), 16'(ACK_WIDTH));
    end
    att = 1'b1;
    buttons = 16'hFFFF;
    cycles(10);

    // Bad first command byte: one rx_valid, then silence.
    r0 = rx_q.size(); a0 = ack_dly_q.size();
    att = 1'b0;
    cycles(10);
    send_byte(8'h81, 20, d);
    send_byte(8'h42, 20, d);
    check("ign_dat1", {8'd0, d}, 16'h00FF);
    send_byte(8'h00, 20, d);
    check("ign_dat2", {8'd0, d}, 16'h00FF);
    check("ign_rx_count", 16'(rx_q.size() - r0), 16'd1);
    check("ign_rx0", {8'd0, rx_q[r0]}, 16'h0081);
    check("ign_ack_count", 16'(ack_dly_q.size() - a0), 16'd0);
    att = 1'b1;
    cycles(10);

    // Deselect after 3 bits of byte 2.
    r0 = rx_q.size();
    att = 1'b0;
    cycles(10);
    send_byte(8'h01, 20, d);
    send_byte(8'h42, 20, d);
    send_bits(8'h00, 3);
    check("abort_dat_before", {15'd0, dat}, 16'd0);
    att = 1'b1;
    cycles(2);
    check("abort_dat_2cyc", {15'd0, dat}, 16'd0);
    cycles(1);
    check("abort_dat_3cyc", {15'd0, dat}, 16'd1);
    check("abort_ack_3cyc", {15'd0, ack}, 16'd1);
    cycles(10);
    check("abort_rx_count", 16'(rx_q.size() - r0), 16'd2);

    // Host clocks byte 2 five cycles after byte 1: ack suppressed.
    r0 = rx_q.size();
    att = 1'b0;
    cycles(10);
    send_byte(8'h01, 20, d);
    a0 = ack_dly_q.size();
    send_byte(8'h42, 5, d);
    send_byte(8'h00, 5, d);
    check("early_dat2", {8'd0, d}, 16'h005A);
    check("early_ack_count", 16'(ack_dly_q.size() - a0), 16'd0);
    check("early_rx2", {8'd0, rx_q[r0 + 2]}, 16'h0000);
    att = 1'b1;
    cycles(20);

    // Reset mid-frame with att held low: stays idle until a fresh select.
    att = 1'b0;
    cycles(10);
    send_byte(8'h01, 20, d);
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    check("mrst_rx_byte", {8'd0, rx_byte}, 16'h0000);
    check("mrst_dat", {15'd0, dat}, 16'd1);
    r0 = rx_q.size();
    cycles(10);
    send_byte(8'h42, 20, d);
    check("mrst_idle_dat", {8'd0, d}, 16'h00FF);
    check("mrst_idle_rx", 16'(rx_q.size() - r0), 16'd0);
    att = 1'b1;
    cycles(10);
    att = 1'b0;
    cycles(10);
    send_byte(8'h01, 20, d);
    send_byte(8'h42, 20, d);
    check("mrst_resel_id", {8'd0, d}, {8'd0, EXP_ID});
    check("mrst_resel_rx", 16'(rx_q.size() - r0), 16'd2);
    att = 1'b1;
    cycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psx_pad_responder.md
PSX_PAD_RESPONDER -- requirements
Module: psx_pad_responder

Interface
REQ-001 SHALL have parameter ACK_DELAY, default 8, meaning clk cycles from a byte's 8th sampled psx_clk rise to ack assertion (legal 1..255).
REQ-002 SHALL have parameter ACK_WIDTH, default 4, meaning clk cycles ack is held low (legal 1..255).
REQ-003 SHALL have port clk, input, 1, system clock (500 ns period); all logic on negedge clk.
REQ-004 SHALL have port rst_n, input, 1; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port att, input, 1, asynchronous host select, active-low.
REQ-006 SHALL have port psx_clk, input, 1, asynchronous host bit clock, idle high.
REQ-007 SHALL have port cmd, input, 1, asynchronous host command bit, LSB first.
REQ-008 SHALL have port buttons, input, 16, active-low button state, bit 0 = SELECT.
REQ-009 SHALL have port dat, output, 1, pad reply bit, idle high.
REQ-010 SHALL have port ack, output, 1, per-byte acknowledge, active-low.
REQ-011 SHALL have port rx_byte, output, 8, last complete command byte received.
REQ-012 SHALL have port rx_valid, output, 1, one-cycle pulse when rx_byte updates.

Function
REQ-013 SHALL pass att, psx_clk, cmd through 2-flop synchronizers; edges detected on synchronized psx_clk; outputs respond 3 clk cycles after the raw input change.
REQ-014 SHALL implement states IDLE, SHIFT, ACK_WAIT, ACK_LOW, IGNORE, DONE.
REQ-015 SHALL in IDLE hold dat=1, ack=1, bit_cnt=0, byte_idx=0.
REQ-016 SHALL on synchronized att fall: snapshot buttons, load tx byte 0, drive dat=tx[0], enter SHIFT.
REQ-017 SHALL in SHIFT drive dat=tx[bit_cnt] on each psx_clk fall; on each rise sample cmd into rx_shift[bit_cnt] and increment bit_cnt.
REQ-018 SHALL after the 8th rise update rx_byte, pulse rx_valid, reset bit_cnt, increment byte_idx.
REQ-019 SHALL transmit tx bytes: idx0 0xFF, idx1 ID 0x41, idx2 0x5A, idx3 buttons[7:0], idx4 buttons[15:8] (snapshot values).
REQ-020 SHALL enter IGNORE if byte 0 received != 0x01 or byte 1 != 0x42; IGNORE holds dat=1, ack=1, no further rx_valid until att rises.
REQ-021 SHALL after a non-final byte enter ACK_WAIT for ACK_DELAY cycles, then ACK_LOW (ack=0) for ACK_WIDTH cycles, then SHIFT with ack=1.
REQ-022 SHALL after the final byte enter DONE: no ack, dat=1, wait for att rise.
REQ-023 SHALL on a psx_clk fall during ACK_WAIT/ACK_LOW release ack that cycle, enter SHIFT, and treat the edge as bit 0 drive.
REQ-024 SHALL on synchronized att rise in any state return to IDLE next cycle with dat=1, ack=1; partial byte discarded, no rx_valid.
REQ-025 SHALL ignore psx_clk edges while att is high.

Reset
REQ-026 SHALL on rst_n=0 at a clock edge set state IDLE, dat=1, ack=1, rx_byte=0x00, rx_valid=0, counters 0, synchronizers to 1.
REQ-027 SHALL after mid-transaction reset with att still low remain in IDLE until att is seen high then low again.

Configuration
REQ-028 SHALL with PSX_PAD_ANALOG_EN defined report ID 0x73 and append idx5..idx8 = 0x80 each (final byte idx8); without it ID 0x41 and final byte idx4.

Verification
REQ-029 SHALL cover: att low, host sends 01 42 00 00 00, buttons=0xFFFE -> dat bytes FF 41 5A FE FF; 4 ack pulses of 4 cycles each 8 cycles after byte end; rx_valid x5.
REQ-030 SHALL cover: first byte 0x81 -> rx_valid once with rx_byte=0x81, then dat=1, no ack until att high.
REQ-031 SHALL cover: att raised after 3 bits of byte 2 -> IDLE within 3 cycles, dat=1, ack=1, no rx_valid for byte 2.
REQ-032 SHALL cover: host psx_clk fall 5 cycles after byte-1 end (ACK_DELAY=8) -> ack never asserted, byte 2 shifts correctly as 0x5A.
REQ-033 SHALL cover: buttons change 0xFFFE->0x0000 mid-frame -> transmitted bytes 3,4 remain FE FF.
REQ-034 SHALL cover: PSX_PAD_ANALOG_EN defined, 9-byte frame -> dat FF 73 5A btn btn 80 80 80 80, 8 ack pulses.
